// File: rtl/segasys1_vramarb.sv
// rtl/segasys1_vramarb.sv - shares one synchronous video RAM between BG, SP and the main CPU
module segasys1_vramarb #(
    parameter int AW          = 12,
    parameter int CPU_MAXWAIT = 6
) (
    input  logic          CLK48M,
    input  logic          RESETn,
    input  logic          BG_REQ,
    input  logic [AW-1:0] BG_AD,
    output logic          BG_GNT,
    output logic          BG_ACK,
    input  logic          SP_REQ,
    input  logic [AW-1:0] SP_AD,
    output logic          SP_GNT,
    output logic          SP_ACK,
    output logic [7:0]    RDATA,
    input  logic          CPU_CS,
    input  logic          CPU_WR,
    input  logic [AW-1:0] CPU_AD,
    input  logic [7:0]    CPU_DO,
    output logic [7:0]    CPU_DI,
    output logic          CPU_RDY,
    output logic [AW-1:0] RAM_AD,
    output logic          RAM_WE,
    output logic [7:0]    RAM_DO,
    input  logic [7:0]    RAM_DI
);

    localparam int CW = (CPU_MAXWAIT < 1) ? 1 : $clog2(CPU_MAXWAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CPU_MAXWAIT);

    typedef enum logic [1:0] {C_IDLE, C_PEND, C_DONE} cpu_state_t;
    typedef enum logic [2:0] {T_NONE, T_BG, T_SP, T_CPUR, T_CPUW} tag_t;

    cpu_state_t    state, state_n;
    tag_t          s1_tag, s2_tag, s1_tag_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] tup_ad;
    logic          tup_wr;
    logic          cpu_req, tuple_chg;
    logic          gnt_bg, gnt_sp, gnt_cpu;
    logic [AW-1:0] iss_ad;
    logic          rdy_n;

    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            state <= C_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        // A CPU read stays in C_PEND while in flight; it must not be re-issued meanwhile.
        cpu_req   = (state == C_PEND) && CPU_CS && (s1_tag != T_CPUR) && (s2_tag != T_CPUR);
        tuple_chg = ({CPU_AD, CPU_WR} != {tup_ad, tup_wr});

        gnt_bg  = 1'b0;
        gnt_sp  = 1'b0;
        gnt_cpu = 1'b0;
        if (cpu_req && (cnt == CNT_MAX)) begin
            gnt_cpu = 1'b1;
        end else if (BG_REQ) begin
            gnt_bg = 1'b1;
        end else if (SP_REQ) begin
            gnt_sp = 1'b1;
        end else if (cpu_req) begin
            gnt_cpu = 1'b1;
        end

        iss_ad   = gnt_bg ? BG_AD : (gnt_sp ? SP_AD : CPU_AD);
        s1_tag_n = T_NONE;
        if (gnt_bg) begin
            s1_tag_n = T_BG;
        end else if (gnt_sp) begin
            s1_tag_n = T_SP;
        end else if (gnt_cpu) begin
            s1_tag_n = CPU_WR ? T_CPUW : T_CPUR;
        end

        state_n = state;
        if (!CPU_CS) begin
            state_n = C_IDLE;
        end else begin
            case (state)
                C_IDLE: state_n = C_PEND;
                C_PEND: begin
                    if (gnt_cpu && CPU_WR) begin
                        state_n = C_DONE;
                    end else if ((s2_tag == T_CPUR) && !tuple_chg) begin
                        state_n = C_DONE;
                    end
                end
                C_DONE: if (tuple_chg) state_n = C_PEND;
                default: state_n = C_IDLE;
            endcase
        end

        cnt_n = cnt;
        if ((state_n != C_PEND) || gnt_cpu) begin
            cnt_n = '0;
        end else if (cpu_req && (cnt != CNT_MAX)) begin
            cnt_n = cnt + 1'b1;
        end

        // Write completes once the RAM has sampled it; read completes when data lands.
        rdy_n = CPU_RDY;
        if (state_n != C_DONE) begin
            rdy_n = 1'b0;
        end else if ((s1_tag == T_CPUW) || (s2_tag == T_CPUR)) begin
            rdy_n = 1'b1;
        end
    end

    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            s1_tag  <= T_NONE;
            s2_tag  <= T_NONE;
            cnt     <= '0;
            tup_ad  <= '0;
            tup_wr  <= 1'b0;
            RAM_AD  <= '0;
            RAM_WE  <= 1'b0;
            RAM_DO  <= 8'h00;
            BG_GNT  <= 1'b0;
            SP_GNT  <= 1'b0;
            BG_ACK  <= 1'b0;
            SP_ACK  <= 1'b0;
            RDATA   <= 8'h00;
            CPU_DI  <= 8'hFF;
            CPU_RDY <= 1'b0;
        end else begin
            s1_tag  <= s1_tag_n;
            s2_tag  <= s1_tag;
            cnt     <= cnt_n;
            CPU_RDY <= rdy_n;
            BG_GNT  <= gnt_bg;
            SP_GNT  <= gnt_sp;
            RAM_WE  <= gnt_cpu && CPU_WR;
            if (gnt_bg || gnt_sp || gnt_cpu) begin
                RAM_AD <= iss_ad;
            end
            if (gnt_cpu) begin
                tup_ad <= CPU_AD;
                tup_wr <= CPU_WR;
                if (CPU_WR) begin
                    RAM_DO <= CPU_DO;
                end
            end
            BG_ACK <= (s2_tag == T_BG);
            SP_ACK <= (s2_tag == T_SP);
            if ((s2_tag == T_BG) || (s2_tag == T_SP)) begin
                RDATA <= RAM_DI;
            end
            if (s2_tag == T_CPUR) begin
                CPU_DI <= RAM_DI;
            end
        end
    end

endmodule

// File: tb/tb_segasys1_vramarb.sv
// tb/tb_segasys1_vramarb.sv - directed self-checking bench for segasys1_vramarb
module tb_segasys1_vramarb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bg_req, sp_req, cpu_cs, cpu_wr;
    logic [11:0] bg_ad, sp_ad, cpu_ad;
    logic [7:0]  cpu_do;
    logic        bg_gnt, bg_ack, sp_gnt, sp_ack, cpu_rdy, ram_we;
    logic [7:0]  rdata, cpu_di, ram_do, ram_di;
    logic [11:0] ram_ad;
    logic [7:0]  mem [0:4095];

    int checks = 0;
    int errs   = 0;
    int we_cnt = 0;
    int ack_cnt = 0;

    always #5 clk = ~clk;

    segasys1_vramarb dut (
        .CLK48M(clk), .RESETn(rst_n),
        .BG_REQ(bg_req), .BG_AD(bg_ad), .BG_GNT(bg_gnt), .BG_ACK(bg_ack),
        .SP_REQ(sp_req), .SP_AD(sp_ad), .SP_GNT(sp_gnt), .SP_ACK(sp_ack),
        .RDATA(rdata),
        .CPU_CS(cpu_cs), .CPU_WR(cpu_wr), .CPU_AD(cpu_ad), .CPU_DO(cpu_do),
        .CPU_DI(cpu_di), .CPU_RDY(cpu_rdy),
        .RAM_AD(ram_ad), .RAM_WE(ram_we), .RAM_DO(ram_do), .RAM_DI(ram_di)
    );

    // RAM contents: low address byte XOR 96, except 0x123 = 5A.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h96;
            mem[12'h123] <= 8'h5A;
        end else if (ram_we) begin
            mem[ram_ad] <= ram_do;
        end
        ram_di <= mem[ram_ad];
    end

    always @(negedge clk) begin
        if (ram_we) we_cnt++;
        if (bg_ack || sp_ack) ack_cnt++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        int we0;
        rst_n = 1'b0; bg_req = 0; sp_req = 0; cpu_cs = 0; cpu_wr = 0;
        bg_ad = '0; sp_ad = '0; cpu_ad = '0; cpu_do = '0;
        step(3);
        rst_n = 1'b1;
        we0 = we_cnt;
        step(5);
        checks++; if ({ram_ad, ram_we, ram_do} !== 21'h0) begin errs++; $display("FAIL reset_ram: got ad=%h we=%b do=%h expected 000/0/00", ram_ad, ram_we, ram_do); end
        checks++; if ({bg_gnt, sp_gnt, bg_ack, sp_ack} !== 4'b0) begin errs++; $display("FAIL reset_gnt_ack: got %b expected 0000", {bg_gnt, sp_gnt, bg_ack, sp_ack}); end
        checks++; if (rdata !== 8'h00) begin errs++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        checks++; if (cpu_di !== 8'hFF) begin errs++; $display("FAIL reset_cpu_di: got %h expected ff", cpu_di); end
        checks++; if (cpu_rdy !== 1'b0) begin errs++; $display("FAIL reset_cpu_rdy: got %b expected 0", cpu_rdy); end
        checks++; if (we_cnt - we0 != 0) begin errs++; $display("FAIL reset_no_we: got %0d pulses expected 0", we_cnt - we0); end
    endtask

    task automatic test_cpu_override;
        int bg_seen = 0;
        step(3);
        bg_req = 1; bg_ad = 12'h040;
        cpu_cs = 1; cpu_wr = 0; cpu_ad = 12'h123;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (i >= 2 && i <= 7 && bg_gnt) bg_seen++;
            if (i == 5) begin
                checks++; if ({bg_ack, rdata} !== {1'b1, 8'hD6}) begin errs++; $display("FAIL ovr_bg_data: got ack=%b rdata=%h expected 1/d6", bg_ack, rdata); end
            end
            if (i == 8) begin
                checks++; if (bg_seen != 6) begin errs++; $display("FAIL ovr_wait_cycles: got %0d lost cycles expected 6", bg_seen); end
                checks++; if ({bg_gnt, ram_ad, ram_we} !== {1'b0, 12'h123, 1'b0}) begin errs++; $display("FAIL ovr_cpu_issue: got gnt=%b ad=%h we=%b expected 0/123/0", bg_gnt, ram_ad, ram_we); end
            end
            if (i == 9) begin
                checks++; if ({bg_gnt, cpu_rdy} !== 2'b10) begin errs++; $display("FAIL ovr_bg_regrant: got gnt=%b rdy=%b expected 1/0", bg_gnt, cpu_rdy); end
            end
            if (i == 10) begin
                checks++; if ({cpu_di, cpu_rdy, bg_ack} !== {8'h5A, 1'b1, 1'b0}) begin errs++; $display("FAIL ovr_cpu_data: got di=%h rdy=%b bg_ack=%b expected 5a/1/0", cpu_di, cpu_rdy, bg_ack); end
            end
        end
        cpu_cs = 0; bg_req = 0;
        step(1);
        checks++; if ({cpu_rdy, cpu_di} !== {1'b0, 8'h5A}) begin errs++; $display("FAIL ovr_cs_release: got rdy=%b di=%h expected 0/5a", cpu_rdy, cpu_di); end
    endtask

    task automatic test_bg_sp;
        step(3);
        bg_req = 1; bg_ad = 12'h040;
        sp_req = 1; sp_ad = 12'h081;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            case (i)
                1: begin checks++; if ({bg_gnt, sp_gnt} !== 2'b10) begin errs++; $display("FAIL bgsp_first: got bg=%b sp=%b expected 1/0", bg_gnt, sp_gnt); end end
                2: begin checks++; if ({bg_gnt, sp_gnt} !== 2'b01) begin errs++; $display("FAIL bgsp_second: got bg=%b sp=%b expected 0/1", bg_gnt, sp_gnt); end end
                3: begin checks++; if ({bg_ack, sp_ack, rdata} !== {2'b10, 8'hD6}) begin errs++; $display("FAIL bgsp_bg_ack: got %b%b %h expected 10 d6", bg_ack, sp_ack, rdata); end end
                4: begin checks++; if ({bg_ack, sp_ack, rdata} !== {2'b01, 8'h17}) begin errs++; $display("FAIL bgsp_sp_ack: got %b%b %h expected 01 17", bg_ack, sp_ack, rdata); end end
                5: begin checks++; if ({bg_ack, sp_ack} !== 2'b00) begin errs++; $display("FAIL bgsp_idle: got %b%b expected 00", bg_ack, sp_ack); end end
                default: ;
            endcase
            if (bg_gnt) bg_req = 0;
            if (sp_gnt) sp_req = 0;
        end
    endtask

    task automatic test_cpu_write;
        int we0;
        step(3);
        we0 = we_cnt;
        cpu_cs = 1; cpu_wr = 1; cpu_ad = 12'h0FF; cpu_do = 8'h3C;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            if (i == 2) begin
                checks++; if ({ram_we, ram_ad, ram_do, cpu_rdy} !== {1'b1, 12'h0FF, 8'h3C, 1'b0}) begin errs++; $display("FAIL wr_issue: got we=%b ad=%h do=%h rdy=%b expected 1/0ff/3c/0", ram_we, ram_ad, ram_do, cpu_rdy); end
            end
            if (i == 3) begin
                checks++; if ({ram_we, cpu_rdy} !== 2'b01) begin errs++; $display("FAIL wr_ready: got we=%b rdy=%b expected 0/1", ram_we, cpu_rdy); end
            end
        end
        checks++; if (cpu_rdy !== 1'b1) begin errs++; $display("FAIL wr_rdy_held: got %b expected 1", cpu_rdy); end
        checks++; if (we_cnt - we0 != 1) begin errs++; $display("FAIL wr_single_pulse: got %0d pulses expected 1", we_cnt - we0); end
        cpu_cs = 0; cpu_wr = 0;
        step(1);
        checks++; if (cpu_rdy !== 1'b0) begin errs++; $display("FAIL wr_rdy_clear: got %b expected 0", cpu_rdy); end
        checks++; if (mem[12'h0FF] !== 8'h3C) begin errs++; $display("FAIL wr_ram_content: got %h expected 3c", mem[12'h0FF]); end
    endtask

    task automatic test_back_to_back;
        step(3);
        cpu_cs = 1; cpu_wr = 0; cpu_ad = 12'h010;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (i == 2) begin
                checks++; if ({ram_ad, ram_we} !== {12'h010, 1'b0}) begin errs++; $display("FAIL b2b_read1: got ad=%h we=%b expected 010/0", ram_ad, ram_we); end
            end
            if (i == 4) begin
                checks++; if ({cpu_di, cpu_rdy} !== {8'h86, 1'b1}) begin errs++; $display("FAIL b2b_data1: got di=%h rdy=%b expected 86/1", cpu_di, cpu_rdy); end
            end
            if (i == 5) cpu_ad = 12'h011;
            if (i == 6) begin
                checks++; if (cpu_rdy !== 1'b0) begin errs++; $display("FAIL b2b_rdy_gap: got %b expected 0", cpu_rdy); end
            end
            if (i == 7) begin
                checks++; if ({ram_ad, ram_we} !== {12'h011, 1'b0}) begin errs++; $display("FAIL b2b_read2: got ad=%h we=%b expected 011/0", ram_ad, ram_we); end
            end
            if (i == 9) begin
                checks++; if ({cpu_di, cpu_rdy} !== {8'h87, 1'b1}) begin errs++; $display("FAIL b2b_data2: got di=%h rdy=%b expected 87/1", cpu_di, cpu_rdy); end
            end
        end
        cpu_cs = 0;
    endtask

    task automatic test_abort;
        int we0;
        step(3);
        we0 = we_cnt;
        bg_req = 1; bg_ad = 12'h040;
        cpu_cs = 1; cpu_wr = 1; cpu_ad = 12'h200; cpu_do = 8'h77;
        step(3);
        cpu_cs = 0;
        step(10);
        bg_req = 0; cpu_wr = 0;
        step(3);
        checks++; if (we_cnt - we0 != 0) begin errs++; $display("FAIL abort_no_we: got %0d pulses expected 0", we_cnt - we0); end
        checks++; if (cpu_rdy !== 1'b0) begin errs++; $display("FAIL abort_rdy: got %b expected 0", cpu_rdy); end
        checks++; if (mem[12'h200] !== 8'h96) begin errs++; $display("FAIL abort_ram_content: got %h expected 96", mem[12'h200]); end
    endtask

    task automatic test_reset_midflight;
        int ack0;
        step(3);
        bg_req = 1; bg_ad = 12'h040;
        step(1);
        checks++; if (bg_gnt !== 1'b1) begin errs++; $display("FAIL rst_pre_gnt: got %b expected 1", bg_gnt); end
        bg_req = 0;
        step(1);
        ack0 = ack_cnt;
        rst_n = 1'b0;
        #1;
        checks++; if ({ram_ad, ram_we, ram_do, bg_gnt, bg_ack} !== 23'h0) begin errs++; $display("FAIL rst_async_ram: got ad=%h we=%b do=%h gnt=%b ack=%b expected all 0", ram_ad, ram_we, ram_do, bg_gnt, bg_ack); end
        checks++; if ({rdata, cpu_di, cpu_rdy} !== {8'h00, 8'hFF, 1'b0}) begin errs++; $display("FAIL rst_async_data: got rdata=%h di=%h rdy=%b expected 00/ff/0", rdata, cpu_di, cpu_rdy); end
        step(2);
        rst_n = 1'b1;
        step(2);
        checks++; if (ack_cnt - ack0 != 0) begin errs++; $display("FAIL rst_ack_dropped: got %0d acks expected 0", ack_cnt - ack0); end
        checks++; if ({rdata, ram_we} !== 9'h0) begin errs++; $display("FAIL rst_after: got rdata=%h we=%b expected 00/0", rdata, ram_we); end
    endtask

    initial begin
        test_reset();
        test_cpu_override();
        test_bg_sp();
        test_cpu_write();
        test_back_to_back();
        test_abort();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
